pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges the combinational load-use stall request, EX-stage taken-branch redirects, data-memory wait handshakes and halt requests into one prioritised set of pipeline-register enables and flushes. Owns the boot hold after reset and a data-memory timeout watchdog. Sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX and EX/MEM register controls.

## Interface
- BOOT_CYCLES, 4: cycles the PC is held after reset release (1..15)
- TIMEOUT, 255: max consecutive MEM_WAIT cycles before fault (1..255)
- CNT_WIDTH, 32: width of performance counters
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- load_use_stall  in  1  stall request from hazard detection unit (same cycle)
- branch_taken  in  1  EX-stage branch/jump resolved taken
- dmem_req  in  1  MEM stage is issuing a load/store this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- halt_req  in  1  ecall/ebreak reached WB
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID cleared to NOP on this edge
- id_ex_flush  out  1  ID/EX cleared to bubble on this edge
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold contents
- halted  out  1  pipeline stopped
- mem_fault  out  1  sticky: memory timeout occurred
- stall_count  out  CNT_WIDTH  cycles with pc_write=0 outside BOOT/HALT (PERF_CNT_EN only)
- flush_count  out  CNT_WIDTH  taken-branch flush events (PERF_CNT_EN only)

## Operation
- States: BOOT, RUN, MEM_WAIT, HALT. Reset -> BOOT, boot counter = 0.
- BOOT: pc_write=if_id_write=0, if_id_flush=id_ex_flush=1, ex_mem_hold=0. After BOOT_CYCLES cycles -> RUN.
- RUN, priority highest first (Mealy, same-cycle outputs):
  - halt_req: all enables 0, ex_mem_hold=1; next HALT.
  - dmem_req && !dmem_ready: freeze — pc_write=if_id_write=0, ex_mem_hold=1, no flushes; next MEM_WAIT, wait counter = 1.
  - branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1; load_use_stall ignored.
  - load_use_stall: pc_write=0, if_id_write=0, id_ex_flush=1.
  - otherwise: pc_write=if_id_write=1, flushes 0, ex_mem_hold=0.
- MEM_WAIT: freeze outputs as above while dmem_ready=0; counter increments. On dmem_ready=1: RUN rules applied this cycle, except dmem_req is treated as satisfied, next RUN. branch_taken/load_use_stall held in frozen EX/ID remain valid and are acted on that cycle.
- Counter reaching TIMEOUT with dmem_ready=0: mem_fault=1 (sticky), next HALT.
- HALT: pc_write=if_id_write=0, ex_mem_hold=1, flushes 0, halted=1. Exit only by reset.
- Wait counter is 8 bits; cleared on entry to RUN.

## Timing
- Reset values: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_hold=0, halted=0, mem_fault=0, counters 0.
- Control outputs combinational from state + inputs; zero-cycle latency from load_use_stall/branch_taken/dmem_ready.
- First pc_write=1 occurs BOOT_CYCLES cycles after rst_n deasserts.
- halted asserts the cycle after halt_req is sampled in RUN.
- dmem_ready=1 in the same cycle as dmem_req: no MEM_WAIT entry, zero stall.
- rst_n assertion mid-MEM_WAIT or HALT: immediate return to BOOT, mem_fault cleared.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_count and flush_count ports exist; stall_count +1 each RUN/MEM_WAIT cycle with pc_write=0; flush_count +1 each cycle branch_taken is acted upon; both wrap at 2^CNT_WIDTH.
- Undefined: ports and counter logic absent; all other behaviour identical.

## Test plan
- Reset release, BOOT_CYCLES=4 -> pc_write 0 for cycles 0-3, 1 at cycle 4; flushes high throughout BOOT.
- RUN, load_use_stall=1 one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; stall_count=1.
- branch_taken=1 with load_use_stall=1 -> if_id_flush=id_ex_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- dmem_req=1, dmem_ready low 3 cycles then high -> freeze 3 cycles, released on 4th; stall_count=3.
- dmem_ready held 0, TIMEOUT=8 -> mem_fault=1 and halted=1 after 8 wait cycles; rst_n low clears both.
- halt_req=1 in RUN -> next cycle halted=1; further load_use_stall/branch_taken produce no enables.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - prioritised stall/flush sequencer for the 5-stage pipeline
// Optional performance counters (stall_count, flush_count) exist only when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
  parameter int BOOT_CYCLES = 4,
  parameter int TIMEOUT     = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_use_stall,
  input  logic                 branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 halt_req,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_hold,
  output logic                 halted,
  output logic                 mem_fault
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_fault_q, mem_fault_d;
  // Set when the normal issue rules (branch / load-use / advance) decide this cycle.
  logic       proceed;

  // Next-state and Mealy control outputs; halt and memory freeze outrank branch and load-use.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;
    proceed     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      ST_RUN: begin
        if (halt_req) begin
          ex_mem_hold = 1'b1;
          state_d     = ST_HALT;
        end else if (dmem_req && !dmem_ready) begin
          ex_mem_hold = 1'b1;
          wait_cnt_d  = 8'd1;
          // A one-cycle budget is already exhausted by the first miss cycle.
          if (TIMEOUT_W <= 9'd1) begin
            mem_fault_d = 1'b1;
            state_d     = ST_HALT;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          proceed = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          ex_mem_hold = 1'b1;
          if (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_W) begin
            mem_fault_d = 1'b1;
            state_d     = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          // Access completes: the frozen EX/ID contents are acted on now.
          wait_cnt_d = 8'd0;
          if (halt_req) begin
            ex_mem_hold = 1'b1;
            state_d     = ST_HALT;
          end else begin
            state_d = ST_RUN;
            proceed = 1'b1;
          end
        end
      end

      default: begin
        ex_mem_hold = 1'b1;
      end
    endcase

    if (proceed) begin
      if (branch_taken) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_stall) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end

    halted    = (state_q == ST_HALT);
    mem_fault = mem_fault_q;
  end

  // State, boot/wait counters and sticky fault flag; reset returns to BOOT from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 4'd0;
      wait_cnt_q  <= 8'd0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  // Stalls count only live-pipeline cycles; a branch is acted on exactly when PC advances with a flush.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !pc_write)
      stall_count_d = stall_count_q + CNT_ONE;
    if (pc_write && if_id_flush)
      flush_count_d = flush_count_q + CNT_ONE;
  end

  // Performance counter registers, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - table-driven scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic load_use_stall, branch_taken, dmem_req, dmem_ready, halt_req;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, halted, mem_fault;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .BOOT_CYCLES(4),
    .TIMEOUT(8),
    .CNT_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_use_stall(load_use_stall),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .halt_req(halt_req),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold),
    .halted(halted),
    .mem_fault(mem_fault)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_count(stall_count),
    .flush_count(flush_count)
`endif
  );

  // exp = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, halted, mem_fault}
  typedef struct {
    logic       lus;
    logic       bt;
    logic       req;
    logic       rdy;
    logic       halt;
    logic [6:0] exp;
    logic       chk;
    int         stall;
    int         flush;
  } vec_t;

  localparam logic [6:0] O_BOOT  = 7'b0011000;
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_LUS   = 7'b0001000;
  localparam logic [6:0] O_BR    = 7'b1111000;
  localparam logic [6:0] O_FRZ   = 7'b0000100;
  localparam logic [6:0] O_HALT  = 7'b0000110;
  localparam logic [6:0] O_FAULT = 7'b0000111;

  int   total  = 0;
  int   passed = 0;
  vec_t tbl[$];
  logic [6:0] sb_q[$];

  function automatic vec_t mk(input logic lus, input logic bt, input logic req, input logic rdy,
                              input logic halt, input logic [6:0] e, input logic chk,
                              input int st, input int fl);
    vec_t v;
    v.lus = lus; v.bt = bt; v.req = req; v.rdy = rdy; v.halt = halt;
    v.exp = e; v.chk = chk; v.stall = st; v.flush = fl;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, halted, mem_fault};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called just after a rising edge: drive one cycle, compare mid-cycle, then step the clock.
  task automatic apply(input string name, input vec_t v);
    logic [6:0] e;
    load_use_stall = v.lus;
    branch_taken   = v.bt;
    dmem_req       = v.req;
    dmem_ready     = v.rdy;
    halt_req       = v.halt;
    sb_q.push_back(v.exp);
    @(negedge clk);
    e = sb_q.pop_front();
    check(name, 64'(outs()), 64'(e));
    @(posedge clk);
    #1;
`ifdef PIPE_PERF_CNT_EN
    if (v.chk) begin
      check({name, "_stall"}, 64'(stall_count), 64'(v.stall));
      check({name, "_flush"}, 64'(flush_count), 64'(v.flush));
    end
`endif
  endtask

  task automatic boot_rows(input string tag);
    for (int i = 0; i < 4; i++)
      apply($sformatf("%s_boot%0d", tag, i), mk(0, 0, 0, 0, 0, O_BOOT, 1'b0, 0, 0));
  endtask

  task automatic reset_now(input string name);
    rst_n = 1'b0;
    #1;
    check(name, 64'(outs()), 64'(O_BOOT));
`ifdef PIPE_PERF_CNT_EN
    check({name, "_cnt"}, 64'({stall_count, flush_count}), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    load_use_stall = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0; halt_req = 0;

    // Boot window then single-cycle RUN behaviours, with cumulative counter expectations.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, O_BOOT, 1'b1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, O_RUN,  1'b1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, O_LUS,  1'b1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, O_RUN,  1'b1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, O_BR,   1'b1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, O_BR,   1'b1, 1, 2));
    tbl.push_back(mk(0, 0, 1, 1, 0, O_RUN,  1'b1, 1, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, O_FRZ,  1'b1, 2, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, O_FRZ,  1'b1, 3, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, O_FRZ,  1'b1, 4, 2));
    tbl.push_back(mk(0, 0, 1, 1, 0, O_RUN,  1'b1, 4, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, O_RUN,  1'b1, 4, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, O_FRZ,  1'b1, 5, 2));
    tbl.push_back(mk(0, 1, 1, 1, 0, O_BR,   1'b1, 5, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, O_FRZ,  1'b1, 6, 3));
    tbl.push_back(mk(1, 0, 1, 1, 0, O_LUS,  1'b1, 7, 3));
    tbl.push_back(mk(0, 1, 1, 0, 0, O_FRZ,  1'b1, 8, 3));
    tbl.push_back(mk(0, 0, 1, 1, 0, O_RUN,  1'b1, 8, 3));

    #2;
    check("reset_outputs", 64'(outs()), 64'(O_BOOT));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("row%0d", i), tbl[i]);

    // halt_req outranks branch; HALT ignores every later request.
    apply("halt_req",   mk(1, 1, 0, 0, 1, O_FRZ,  1'b0, 0, 0));
    apply("halted_1",   mk(1, 1, 0, 0, 0, O_HALT, 1'b0, 0, 0));
    apply("halted_2",   mk(0, 1, 1, 0, 0, O_HALT, 1'b0, 0, 0));
    apply("halted_3",   mk(0, 0, 0, 0, 0, O_HALT, 1'b0, 0, 0));
    reset_now("rst_in_halt");

    // Data-memory timeout: 8 frozen cycles then fault + halt, cleared by reset.
    boot_rows("to");
    for (int i = 0; i < 8; i++)
      apply($sformatf("to_wait%0d", i), mk(0, 0, 1, 0, 0, O_FRZ, 1'b0, 0, 0));
    apply("to_fault",   mk(0, 0, 1, 0, 0, O_FAULT, 1'b0, 0, 0));
    apply("to_sticky",  mk(0, 1, 0, 1, 0, O_FAULT, 1'b0, 0, 0));
    reset_now("rst_after_fault");

    // Reset in the middle of a memory wait goes straight back to BOOT.
    boot_rows("mw");
    apply("mw_wait0",   mk(0, 0, 1, 0, 0, O_FRZ, 1'b0, 0, 0));
    apply("mw_wait1",   mk(0, 0, 1, 0, 0, O_FRZ, 1'b0, 0, 0));
    reset_now("rst_in_mem_wait");
    boot_rows("post");
    apply("post_run",   mk(0, 0, 0, 0, 0, O_RUN, 1'b0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
